// File: rtl/riscv_scoreboard.sv
// Register-hazard scoreboard for the in-order hart: tracks in-flight rd per pipeline slot.
// Optional operand bypass selection is enabled by defining RISCV_SCOREBOARD_FORWARD_EN.
module riscv_scoreboard #(
  parameter int unsigned REGN  = 32,
  parameter int unsigned REGA  = $clog2(REGN),
  parameter int unsigned DEPTH = 3,
  parameter int unsigned SELW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [REGA-1:0] issue_rd,
  input  logic            issue_rd_we,
  input  logic            issue_load,
  input  logic [REGA-1:0] rs1,
  input  logic [REGA-1:0] rs2,
  input  logic            rs1_used,
  input  logic            rs2_used,
  input  logic            flush,
  output logic            stall,
  output logic [SELW-1:0] fwd1_sel,
  output logic [SELW-1:0] fwd2_sel,
  output logic [REGN-1:0] busy,
  output logic [SELW-1:0] inflight
);

  // Index 0 is slot 1 (EX), index DEPTH-1 is slot DEPTH (WB).
  logic [DEPTH-1:0] slot_valid;
  logic [REGA-1:0]  slot_rd [DEPTH];

  logic [SELW-1:0] hit1_sel;
  logic [SELW-1:0] hit2_sel;
  logic            haz1;
  logic            haz2;
  logic            accept;

  // Scan oldest to youngest so the lowest matching slot wins.
  always_comb begin
    hit1_sel = '0;
    hit2_sel = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rs1_used && (rs1 != '0) && slot_valid[DEPTH-1-i] && (slot_rd[DEPTH-1-i] == rs1))
        hit1_sel = SELW'(DEPTH - i);
      if (rs2_used && (rs2 != '0) && slot_valid[DEPTH-1-i] && (slot_rd[DEPTH-1-i] == rs2))
        hit2_sel = SELW'(DEPTH - i);
    end
  end

`ifdef RISCV_SCOREBOARD_FORWARD_EN
  // Only the EX-slot load flag can cause a hazard, so only that one is kept.
  logic slot1_load;

  always_ff @(posedge clk) begin
    slot1_load <= issue_load;
  end

  assign haz1     = (hit1_sel == SELW'(1)) && slot1_load;
  assign haz2     = (hit2_sel == SELW'(1)) && slot1_load;
  assign fwd1_sel = stall ? '0 : hit1_sel;
  assign fwd2_sel = stall ? '0 : hit2_sel;
`else
  logic unused_load;

  assign unused_load = issue_load;
  assign haz1        = (hit1_sel != '0);
  assign haz2        = (hit2_sel != '0);
  assign fwd1_sel    = '0;
  assign fwd2_sel    = '0;
`endif

  assign stall  = issue_valid && !flush && (haz1 || haz2);
  assign accept = issue_valid && !stall && !flush && issue_rd_we && (issue_rd != '0);

  // A flush kills the EX entry instead of advancing it into slot 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= '0;
    end else begin
      slot_valid[0] <= accept;
      for (int unsigned i = 1; i < DEPTH; i++)
        slot_valid[i] <= slot_valid[i-1] && !(flush && (i == 1));
    end
  end

  always_ff @(posedge clk) begin
    slot_rd[0] <= issue_rd;
    for (int unsigned i = 1; i < DEPTH; i++)
      slot_rd[i] <= slot_rd[i-1];
  end

  always_comb begin
    busy     = '0;
    inflight = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (slot_valid[i])
        busy[slot_rd[i]] = 1'b1;
      inflight = inflight + SELW'(slot_valid[i]);
    end
    busy[0] = 1'b0;
  end

endmodule

// File: tb/tb_riscv_scoreboard.sv
// Directed table-driven bench for riscv_scoreboard (DEPTH=3); expectations follow
// the RISCV_SCOREBOARD_FORWARD_EN setting of the build.
module tb_riscv_scoreboard;

  localparam int unsigned REGN  = 32;
  localparam int unsigned REGA  = 5;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned SELW  = 2;
`ifdef RISCV_SCOREBOARD_FORWARD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic            clk;
  logic            rst;
  logic            issue_valid;
  logic [REGA-1:0] issue_rd;
  logic            issue_rd_we;
  logic            issue_load;
  logic [REGA-1:0] rs1;
  logic [REGA-1:0] rs2;
  logic            rs1_used;
  logic            rs2_used;
  logic            flush;
  logic            stall;
  logic [SELW-1:0] fwd1_sel;
  logic [SELW-1:0] fwd2_sel;
  logic [REGN-1:0] busy;
  logic [SELW-1:0] inflight;

  riscv_scoreboard #(
    .REGN (REGN),
    .REGA (REGA),
    .DEPTH(DEPTH),
    .SELW (SELW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_rd_we(issue_rd_we),
    .issue_load (issue_load),
    .rs1        (rs1),
    .rs2        (rs2),
    .rs1_used   (rs1_used),
    .rs2_used   (rs2_used),
    .flush      (flush),
    .stall      (stall),
    .fwd1_sel   (fwd1_sel),
    .fwd2_sel   (fwd2_sel),
    .busy       (busy),
    .inflight   (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic        fl;
    logic        st;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic [31:0] bz;
    logic [1:0]  nf;
  } vec_t;

  vec_t tbl[$];
  int   checks;
  int   errors;

  function automatic vec_t mk(input int v, input int rd, input int we, input int ld,
                              input int s1, input int u1, input int s2, input int u2,
                              input int fl, input int st, input int f1, input int f2,
                              input int bz, input int nf);
    vec_t t;
    t.v  = 1'(v);   t.rd  = 5'(rd); t.we = 1'(we); t.ld = 1'(ld);
    t.rs1 = 5'(s1); t.u1  = 1'(u1); t.rs2 = 5'(s2); t.u2 = 1'(u2);
    t.fl = 1'(fl);  t.st  = 1'(st); t.f1 = 2'(f1); t.f2 = 2'(f2);
    t.bz = 32'(bz); t.nf  = 2'(nf);
    return t;
  endfunction

  function automatic vec_t idle(input int bz, input int nf);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, bz, nf);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    issue_valid = t.v;   issue_rd = t.rd; issue_rd_we = t.we; issue_load = t.ld;
    rs1 = t.rs1; rs1_used = t.u1; rs2 = t.rs2; rs2_used = t.u2; flush = t.fl;
  endtask

  task automatic check_row(input int idx, input vec_t t);
    chk("stall", idx, 32'(stall), 32'(t.st));
    chk("fwd1_sel", idx, 32'(fwd1_sel), 32'(t.f1));
    chk("fwd2_sel", idx, 32'(fwd2_sel), 32'(t.f2));
    chk("busy", idx, busy, t.bz);
    chk("inflight", idx, 32'(inflight), 32'(t.nf));
  endtask

  initial begin
    int n;
    int done;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(idle(0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", 0, 32'(stall), 0);
    chk("rst_busy", 0, busy, 0);
    chk("rst_inflight", 0, 32'(inflight), 0);
    chk("rst_fwd", 0, 32'({fwd1_sel, fwd2_sel}), 0);

`ifdef RISCV_SCOREBOARD_FORWARD_EN
    // ALU producer forwards from slot 1, 2 and 3; load-use stalls once then forwards from 2.
    tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1, 'h80, 1));
    tbl.push_back(mk(1, 0, 0, 0, 7, 1, 0, 0, 0, 0, 2, 0, 'h80, 1));
    tbl.push_back(mk(1, 0, 0, 0, 7, 1, 0, 0, 0, 0, 3, 0, 'h80, 1));
    tbl.push_back(mk(1, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 10, 1, 0, 9, 1, 0, 0, 0, 1, 0, 0, 'h200, 1));
    tbl.push_back(mk(1, 10, 1, 0, 9, 1, 0, 0, 0, 0, 2, 0, 'h200, 1));
    tbl.push_back(idle('h600, 2));
    tbl.push_back(idle('h400, 1));
    tbl.push_back(idle('h400, 1));
    tbl.push_back(idle(0, 0));
`else
    // Dependent on rd=5 stalls while rd=5 sits in slots 1..3, then is accepted.
    tbl.push_back(idle(0, 0));
    tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 6, 1, 0, 5, 1, 0, 0, 0, 1, 0, 0, 'h20, 1));
    tbl.push_back(mk(1, 6, 1, 0, 5, 1, 0, 0, 0, 1, 0, 0, 'h20, 1));
    tbl.push_back(mk(1, 6, 1, 0, 5, 1, 0, 0, 0, 1, 0, 0, 'h20, 1));
    tbl.push_back(mk(1, 6, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle('h40, 1));
    tbl.push_back(idle('h40, 1));
    tbl.push_back(idle('h40, 1));
    tbl.push_back(idle(0, 0));
`endif
    // x0 destination, unused/x0 sources, slot-2 hit, flush against a slot-1 hit.
    tbl.push_back(mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h40, 1));
    tbl.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h40, 1));
    tbl.push_back(mk(1, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 'h48, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 3, 1, 0, 1 - FWD, 0, FWD * 2, 'h08, 1));
    tbl.push_back(idle('h08, 1));
    tbl.push_back(idle(0, 0));
    tbl.push_back(mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h04, 1));
    tbl.push_back(mk(1, 9, 1, 0, 4, 1, 0, 0, 1, 0, FWD, 0, 'h14, 2));
    tbl.push_back(idle('h04, 1));
    tbl.push_back(idle(0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check_row(i, tbl[i]);
    end

    // Count the stall run of a back-to-back dependent, bounded by a cycle budget.
    @(negedge clk);
    drive(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    n    = 0;
    done = 0;
    for (int c = 0; c < 10 && done == 0; c++) begin
      @(negedge clk);
      drive(mk(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      #1;
      if (stall) n++;
      else done = 1;
    end
    chk("stall_run_len", 0, 32'(n), (FWD != 0) ? 32'd0 : 32'd3);
    chk("stall_run_end", 0, 32'(done), 32'd1);
    repeat (4) begin
      @(negedge clk);
      drive(idle(0, 0));
    end

    // Reset with three valid slots, while an issue is also presented.
    for (int r = 11; r <= 13; r++) begin
      @(negedge clk);
      drive(mk(1, r, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    @(negedge clk);
    drive(idle(0, 0));
    #1;
    chk("pre_rst_inflight", 0, 32'(inflight), 32'd3);
    chk("pre_rst_busy", 0, busy, 32'h3800);
    rst = 1'b1;
    drive(mk(1, 14, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    drive(mk(1, 0, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("mid_rst_inflight", 0, 32'(inflight), 0);
    chk("mid_rst_busy", 0, busy, 0);
    chk("mid_rst_stall", 0, 32'(stall), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_scoreboard.md
# riscv_scoreboard

Parametrised register-hazard tracker for the in-order RISC-V hart pipeline. It sits beside the decode stage and records every in-flight destination register from issue until writeback. It produces the decode stall that inserts bubbles into the fetch/decode stages. With forwarding compiled in, it also produces per-operand bypass selects and stalls only on load-use hazards.

## Interface
- `REGN`, 32, number of architectural registers; x0 is hard-wired zero.
- `REGA`, `$clog2(REGN)`, register address width.
- `DEPTH`, 3, pipeline slots between issue and register-file commit (EX, MA, WB); legal range 1..7.
- `SELW`, `$clog2(DEPTH+1)`, width of bypass selects and of the in-flight count.

Ports (the clock is `clk`; the reset is `rst`, synchronous and active-high):
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous active-high reset.
- `issue_valid` in 1: decode presents an instruction this cycle.
- `issue_rd` in REGA: destination register of the presented instruction.
- `issue_rd_we` in 1: the presented instruction writes `issue_rd`.
- `issue_load` in 1: the presented instruction is a load; its result is available only after MA.
- `rs1`, `rs2` in REGA: source registers of the presented instruction.
- `rs1_used`, `rs2_used` in 1: the corresponding source is actually read.
- `flush` in 1: branch/exception kill; kills slot 1 and drops the current issue.
- `stall` out 1: decode must hold; the fetch bubble input is driven from this.
- `fwd1_sel`, `fwd2_sel` out SELW: 0 = register file, k = result of slot k.
- `busy` out REGN: bitmask of registers with a pending write; bit 0 is always 0.
- `inflight` out SELW: count of valid slots.

## Operation
- State: DEPTH slots, each holding {valid, rd, load}. Slot 1 is EX and slot DEPTH is WB.
- Every cycle, slot[k+1] <= slot[k] for k = 1..DEPTH-1, and the old slot DEPTH retires.
- Slot 1 is loaded with the issued instruction when all of these hold: `issue_valid`, not `stall`, not `flush`, `issue_rd_we`, and `issue_rd != 0`.
- In every other case slot 1 receives a bubble (valid = 0).
- `flush` asserted: the slot-1 entry is discarded; it is not shifted into slot 2. The slot-1 bubble is written regardless of issue. Slots 2..DEPTH keep shifting normally.
- Operand hit on slot k: the operand is used, the source register is nonzero, slot k is valid, and slot k's rd equals the source. Only the youngest hit (lowest k) counts.
- `stall` = `issue_valid` and not `flush` and (hazard on rs1 or hazard on rs2).
- Hazard definition depends on configuration (see below).
- `fwd*_sel` = k of the youngest hit when the operand is not stalled; otherwise 0.
- `busy[r]` = OR over valid slots with rd == r. `inflight` = popcount of the slot valid bits.
- Reset: all slots invalid. Consequently `stall`=0, `fwd1_sel`=`fwd2_sel`=0, `busy`=0, `inflight`=0 from the first cycle after reset.
- `rst` overrides `flush` and issue.

## Timing
- `stall`, `fwd*_sel`, and `busy` are combinational from slot state and current inputs, valid in the same cycle. `inflight` is combinational from slot state.
- An accepted instruction becomes visible in slot 1 one cycle after issue. It leaves the scoreboard DEPTH+1 cycles after issue.
- Without forwarding, a back-to-back dependent instruction stalls exactly DEPTH cycles.
- With forwarding:
  - An ALU producer followed by a dependent instruction: 0 stall cycles.
  - A load followed by a dependent instruction: exactly 1 stall cycle, then `fwd_sel`=2.
- Simultaneous `flush` and hazard: `stall`=0. The issue is dropped because `flush` wins.
- Slot DEPTH counts as a hit. The register file is not write-through; forwarding serves that case.

## Configuration
- `RISCV_SCOREBOARD_FORWARD_EN` defined:
  - The hazard is a slot-1 hit whose entry has load = 1.
  - All other hits forward via `fwd*_sel`.
- `RISCV_SCOREBOARD_FORWARD_EN` undefined:
  - The hazard is any hit in slots 1..DEPTH.
  - `fwd1_sel` and `fwd2_sel` are tied to 0.
  - The `load` field of each slot is not stored.

## Test plan
- Reset mid-operation: with 3 slots valid, assert `rst` for 1 cycle. Next cycle `inflight`=0, `busy`=0, `stall`=0.
- No forwarding, DEPTH=3:
  - Issue rd=5 (ALU), then rs1=5 with `rs1_used`=1.
  - `stall`=1 for exactly 3 cycles.
  - The dependent instruction is accepted in the 4th cycle, when `busy[5]`=0.
- Forwarding, DEPTH=3:
  - Issue rd=7 ALU, then rs2=7 next cycle: `stall`=0, `fwd2_sel`=1.
  - One cycle later, another rs1=7: `fwd1_sel`=2.
- Forwarding load-use: issue a load with rd=9, then rs1=9.
  - `stall`=1 for 1 cycle.
  - Then `fwd1_sel`=2 and the instruction is accepted.
- x0 and unused operands:
  - Issue rd=0 with `issue_rd_we`=1: `inflight` is unchanged.
  - rs1=3 with `rs1_used`=0, while slot 1 holds rd=3: `stall`=0.
- Flush:
  - Issue rd=4, then assert `flush` with the dependent rs1=4 presented. `stall`=0, nothing is accepted, and `busy[4]`=0 on the next cycle.
  - The older entry in slot 2 still retires on schedule.
